// File: rtl/efuse_pgm.sv
// Program-side controller for the 256-bit eFuse macro: burns one NR-bit window,
// one fuse per aen strobe, skipping bits that are 0.
module efuse_pgm #(
   parameter int NR      = 64,
   parameter int RSEL    = 256 / NR,
   parameter int GAP_CYC = 16
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [7:0]                              rg_efuse_tpgm,
   input  logic [((RSEL > 1) ? $clog2(RSEL) : 1)-1:0] pgm_sel,
   input  logic [NR-1:0]                           pgm_data,
   input  logic                                    pgm_start,
   output logic                                    pgm_done,
   output logic                                    busy_pgm,
   output logic [$clog2(NR+1)-1:0]                 pgm_cnt,
   output logic                                    efuse_pgmen_o,
   output logic                                    efuse_rden_o,
   output logic                                    efuse_aen_o,
   output logic [7:0]                              efuse_addr_o
);

   localparam int SW = (RSEL > 1) ? $clog2(RSEL) : 1;
   localparam int IW = $clog2(NR);
   localparam int CW = $clog2(NR + 1);
   localparam int TW = ($clog2(GAP_CYC) > 8) ? $clog2(GAP_CYC) : 8;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_SCAN   = 3'd2;
   localparam logic [2:0] S_PULSE  = 3'd3;
   localparam logic [2:0] S_GAP    = 3'd4;
   localparam logic [2:0] S_FINISH = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [SW-1:0] sel_q, sel_d;
   logic [NR-1:0] data_q, data_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          aen_q, aen_d;
   logic          pgmen_q, pgmen_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [7:0]    addr_q, addr_d;

   logic [IW-1:0] bit_pos;
   logic          cur_bit;
   logic          last_bit;
   logic [4:0]    byte_d;

   // Byte k of the window holds data bits [NR-1-8k -: 8] so a read returns pgm_data unchanged.
   assign bit_pos  = IW'(NR - 8) - (idx_q & ~IW'(7)) + (idx_q & IW'(7));
   assign cur_bit  = data_q[bit_pos];
   assign last_bit = (idx_q == IW'(NR - 1));
   assign byte_d   = 5'((NR / 8) * sel_d) + 5'(idx_d >> 3);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sel_d   = sel_q;
      data_d  = data_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      aen_d   = aen_q;
      pgmen_d = pgmen_q;
      busy_d  = busy_q;
      done_d  = done_q;
      case (state_q)
         S_IDLE: begin
            if (pgm_start) begin
               data_d  = pgm_data;
               sel_d   = pgm_sel;
               idx_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pgmen_d = 1'b1;
               state_d = S_SETUP;
            end
         end
         S_SETUP: state_d = S_SCAN;
         S_SCAN: begin
            if (cur_bit) begin
               aen_d   = 1'b1;
               timer_d = (rg_efuse_tpgm == 8'd0) ? '0 : TW'(rg_efuse_tpgm) - TW'(1);
               state_d = S_PULSE;
            end else if (last_bit) begin
               pgmen_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_FINISH;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         S_PULSE: begin
            if (timer_q == '0) begin
               aen_d   = 1'b0;
               cnt_d   = cnt_q + CW'(1);
               timer_d = TW'(GAP_CYC - 1);
               state_d = S_GAP;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_GAP: begin
            if (timer_q != '0) begin
               timer_d = timer_q - TW'(1);
            end else if (last_bit) begin
               pgmen_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_FINISH;
            end else begin
               idx_d   = idx_q + IW'(1);
               state_d = S_SCAN;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      // idx only moves while aen is low, so the address is stable across pulse and gap.
      addr_d = {idx_d[2:0], byte_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         sel_q   <= '0;
         data_q  <= '0;
         timer_q <= '0;
         cnt_q   <= '0;
         aen_q   <= 1'b0;
         pgmen_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         aen_q   <= aen_d;
         pgmen_q <= pgmen_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         addr_q  <= addr_d;
      end
   end

   assign pgm_done      = done_q;
   assign busy_pgm      = busy_q;
   assign pgm_cnt       = cnt_q;
   assign efuse_pgmen_o = pgmen_q;
   assign efuse_rden_o  = 1'b0;
   assign efuse_aen_o   = aen_q;
   assign efuse_addr_o  = addr_q;

endmodule

// File: tb/tb_efuse_pgm.sv
// Directed bench for efuse_pgm (NR=64, GAP_CYC=16): latency, pulse addresses/widths,
// ignored starts, async reset and a burn/read-back round trip through a fuse-array model.
`timescale 1ns/1ps
module tb_efuse_pgm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rg_efuse_tpgm = 8'd0;
   logic [1:0]  pgm_sel = 2'd0;
   logic [63:0] pgm_data = 64'd0;
   logic        pgm_start = 1'b0;
   logic        pgm_done, busy_pgm;
   logic [6:0]  pgm_cnt;
   logic        efuse_pgmen_o, efuse_rden_o, efuse_aen_o;
   logic [7:0]  efuse_addr_o;

   int n_vec = 0;
   int n_miss = 0;

   efuse_pgm #(.NR(64), .RSEL(4), .GAP_CYC(16)) dut (
      .clk(clk), .rst_n(rst_n), .rg_efuse_tpgm(rg_efuse_tpgm), .pgm_sel(pgm_sel),
      .pgm_data(pgm_data), .pgm_start(pgm_start), .pgm_done(pgm_done), .busy_pgm(busy_pgm),
      .pgm_cnt(pgm_cnt), .efuse_pgmen_o(efuse_pgmen_o), .efuse_rden_o(efuse_rden_o),
      .efuse_aen_o(efuse_aen_o), .efuse_addr_o(efuse_addr_o)
   );

   always #5 clk = ~clk;

   // Pulse monitor, sampled on the falling edge.
   logic       mon_clr = 1'b0;
   int         cyc = 0, pg_cyc = 0, np = 0, viol_pgmen = 0, viol_addr = 0;
   logic       aen_prev = 1'b0;
   logic [7:0] p_addr [256];
   int         p_rise [256];
   int         p_width[256];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (mon_clr) begin
         np = 0; pg_cyc = 0; viol_pgmen = 0; viol_addr = 0; aen_prev = 1'b0;
      end else begin
         if (efuse_pgmen_o) pg_cyc = pg_cyc + 1;
         if (efuse_aen_o && !efuse_pgmen_o) viol_pgmen = viol_pgmen + 1;
         if (np < 256) begin
            if (efuse_aen_o && !aen_prev) begin
               p_addr[np] = efuse_addr_o;
               p_rise[np] = cyc;
            end
            if (efuse_aen_o && aen_prev && efuse_addr_o != p_addr[np]) viol_addr = viol_addr + 1;
            if (!efuse_aen_o && aen_prev) begin
               p_width[np] = cyc - p_rise[np];
               np = np + 1;
            end
         end
         aen_prev = efuse_aen_o;
      end
   end

   // Returns #1 after E0, the edge that samples pgm_start.
   task automatic start_run(input logic [1:0] sel, input logic [63:0] data, input logic [7:0] tpgm);
      @(posedge clk); #1 mon_clr = 1'b1;
      @(posedge clk); #1 mon_clr = 1'b0;
      pgm_sel = sel; pgm_data = data; rg_efuse_tpgm = tpgm; pgm_start = 1'b1;
      @(posedge clk); #1 pgm_start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int lat);
      lat = 0;
      while (!pgm_done && lat < limit) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({pgm_done, busy_pgm, pgm_cnt, efuse_pgmen_o, efuse_aen_o, efuse_addr_o} !== 19'd0) begin
         n_miss++;
         $display("FAIL reset_outputs: got %0h expected 0",
                  {pgm_done, busy_pgm, pgm_cnt, efuse_pgmen_o, efuse_aen_o, efuse_addr_o});
      end
      n_vec++;
      if (efuse_rden_o !== 1'b0) begin
         n_miss++; $display("FAIL reset_rden: got %b expected 0", efuse_rden_o);
      end
      rst_n = 1'b1;
      $display("reset: released");
   endtask

   task automatic test_zero_data();
      int lat;
      start_run(2'd0, 64'd0, 8'd5);
      n_vec++;
      if ({busy_pgm, pgm_done} !== 2'b10) begin
         n_miss++; $display("FAIL zero_start_flags: got %b expected 10", {busy_pgm, pgm_done});
      end
      wait_done(200, lat);
      n_vec++;
      if (lat !== 65) begin n_miss++; $display("FAIL zero_latency: got %0d expected 65", lat); end
      n_vec++;
      if (np !== 0) begin n_miss++; $display("FAIL zero_pulses: got %0d expected 0", np); end
      n_vec++;
      if (pg_cyc !== 65) begin n_miss++; $display("FAIL zero_pgmen_cycles: got %0d expected 65", pg_cyc); end
      n_vec++;
      if ({busy_pgm, efuse_pgmen_o, pgm_cnt} !== 9'd0) begin
         n_miss++; $display("FAIL zero_end_state: got %0h expected 0", {busy_pgm, efuse_pgmen_o, pgm_cnt});
      end
      $display("zero_data: latency %0d pulses %0d", lat, np);
   endtask

   task automatic test_two_bits();
      int lat;
      start_run(2'd1, 64'h8000_0000_0000_0001, 8'd10);
      wait_done(400, lat);
      n_vec++;
      if (lat !== 117) begin n_miss++; $display("FAIL two_latency: got %0d expected 117", lat); end
      n_vec++;
      if (np !== 2) begin n_miss++; $display("FAIL two_pulses: got %0d expected 2", np); end
      n_vec++;
      if (p_addr[0] !== 8'hE8) begin n_miss++; $display("FAIL two_addr0: got %h expected e8", p_addr[0]); end
      n_vec++;
      if (p_addr[1] !== 8'h0F) begin n_miss++; $display("FAIL two_addr1: got %h expected 0f", p_addr[1]); end
      n_vec++;
      if (p_width[0] !== 10 || p_width[1] !== 10) begin
         n_miss++; $display("FAIL two_width: got %0d/%0d expected 10/10", p_width[0], p_width[1]);
      end
      n_vec++;
      if (pgm_cnt !== 7'd2) begin n_miss++; $display("FAIL two_cnt: got %0d expected 2", pgm_cnt); end
      n_vec++;
      if (viol_pgmen + viol_addr !== 0) begin
         n_miss++; $display("FAIL two_strobe_rules: got %0d violations expected 0", viol_pgmen + viol_addr);
      end
      $display("two_bits: latency %0d addrs %h %h", lat, p_addr[0], p_addr[1]);
   endtask

   task automatic test_all_ones();
      int lat, bad_w, bad_a, bad_s;
      logic [5:0] ii;
      start_run(2'd0, {64{1'b1}}, 8'd0);
      wait_done(3000, lat);
      n_vec++;
      if (lat !== 1153) begin n_miss++; $display("FAIL ones_latency: got %0d expected 1153", lat); end
      n_vec++;
      if (np !== 64) begin n_miss++; $display("FAIL ones_pulses: got %0d expected 64", np); end
      bad_w = 0; bad_a = 0; bad_s = 0;
      for (int i = 0; i < 64 && i < np; i++) begin
         ii = 6'(i);
         if (p_width[i] != 1) bad_w++;
         if (p_addr[i] != {ii[2:0], 2'b00, ii[5:3]}) bad_a++;
         if (i < np - 1 && p_rise[i+1] - p_rise[i] != 18) bad_s++;
      end
      n_vec++;
      if (bad_w !== 0) begin n_miss++; $display("FAIL ones_width: got %0d bad expected 0", bad_w); end
      n_vec++;
      if (bad_a !== 0) begin n_miss++; $display("FAIL ones_addr: got %0d bad expected 0", bad_a); end
      n_vec++;
      if (bad_s !== 0) begin n_miss++; $display("FAIL ones_spacing: got %0d bad expected 0", bad_s); end
      n_vec++;
      if (pgm_cnt !== 7'd64) begin n_miss++; $display("FAIL ones_cnt: got %0d expected 64", pgm_cnt); end
      $display("all_ones: latency %0d pulses %0d", lat, np);
   endtask

   task automatic test_ignored_start();
      int lat;
      start_run(2'd1, 64'h8000_0000_0000_0001, 8'd10);
      lat = 0;
      while (!pgm_done && lat < 400) begin
         if (lat == 30) begin
            pgm_sel = 2'd2; pgm_data = {64{1'b1}}; pgm_start = 1'b1;
         end
         @(posedge clk); #1;
         pgm_start = 1'b0;
         lat++;
      end
      n_vec++;
      if (lat !== 117) begin n_miss++; $display("FAIL ignored_latency: got %0d expected 117", lat); end
      n_vec++;
      if (np !== 2 || p_addr[0] !== 8'hE8 || p_addr[1] !== 8'h0F) begin
         n_miss++;
         $display("FAIL ignored_pulses: got n=%0d %h %h expected n=2 e8 0f", np, p_addr[0], p_addr[1]);
      end
      n_vec++;
      if (pgm_cnt !== 7'd2) begin n_miss++; $display("FAIL ignored_cnt: got %0d expected 2", pgm_cnt); end
      $display("ignored_start: latency %0d pulses %0d", lat, np);
   endtask

   task automatic test_reset_mid_pulse();
      int lat, w;
      start_run(2'd0, {64{1'b1}}, 8'd10);
      w = 0;
      while (!efuse_aen_o && w < 50) begin @(posedge clk); #1; w++; end
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({efuse_aen_o, efuse_pgmen_o, busy_pgm, pgm_done, pgm_cnt} !== 11'd0) begin
         n_miss++;
         $display("FAIL async_reset: got %0h expected 0",
                  {efuse_aen_o, efuse_pgmen_o, busy_pgm, pgm_done, pgm_cnt});
      end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      start_run(2'd2, 64'h0000_0000_0000_0100, 8'd10);
      wait_done(300, lat);
      n_vec++;
      if (lat !== 91) begin n_miss++; $display("FAIL fresh_latency: got %0d expected 91", lat); end
      n_vec++;
      if (np !== 1 || p_addr[0] !== 8'h16) begin
         n_miss++; $display("FAIL fresh_pulse: got n=%0d %h expected n=1 16", np, p_addr[0]);
      end
      n_vec++;
      if (pgm_cnt !== 7'd1) begin n_miss++; $display("FAIL fresh_cnt: got %0d expected 1", pgm_cnt); end
      $display("reset_mid_pulse: fresh latency %0d addr %h", lat, p_addr[0]);
   endtask

   task automatic test_readback();
      int lat, pc;
      logic [63:0] data, rd;
      logic [7:0]  fuse [32];
      logic [7:0]  a;
      data = {$urandom, $urandom};
      pc = $countones(data);
      start_run(2'd3, data, 8'd1);
      wait_done(3000, lat);
      for (int b = 0; b < 32; b++) fuse[b] = 8'd0;
      for (int i = 0; i < np && i < 256; i++) begin
         a = p_addr[i];
         fuse[a[4:0]][a[7:5]] = 1'b1;
      end
      rd = 64'd0;
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 8; j++)
            rd[56 - 8*k + j] = fuse[24 + k][j];
      n_vec++;
      if (lat !== 65 + pc * 17) begin
         n_miss++; $display("FAIL readback_latency: got %0d expected %0d", lat, 65 + pc * 17);
      end
      n_vec++;
      if (np !== pc) begin n_miss++; $display("FAIL readback_pulses: got %0d expected %0d", np, pc); end
      n_vec++;
      if (rd !== data) begin n_miss++; $display("FAIL readback_data: got %h expected %h", rd, data); end
      $display("readback: data %h read %h pulses %0d", data, rd, np);
   endtask

   initial begin
      test_reset();
      test_zero_data();
      test_two_bits();
      test_all_ones();
      test_ignored_start();
      test_reset_mid_pulse();
      test_readback();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
